// File: rtl/cnt_ena_ctrl.sv
// Run controller for the 16-bit event counter: start/stop/arm, optional trigger,
// programmable prescaler and one-shot termination on the counter's terminal count.
module cnt_ena_ctrl #(
  parameter int PRESCALE_W = 16
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic                  i_stop,
  input  logic                  i_oneshot,
  input  logic                  i_trig_en,
  input  logic                  i_trig,
  input  logic [PRESCALE_W-1:0] i_prescale,
  input  logic                  i_tc,
  output logic                  o_cnt_ena,
  output logic                  o_running,
  output logic                  o_done
);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_RUN, S_DONE} state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic [PRESCALE_W-1:0]   r_ps_cnt;
  logic [PRESCALE_W-1:0]   r_p;
  logic                    r_oneshot;
  logic                    r_trig_en;
  logic                    r_trig_q;
  logic                    w_latch;
  logic                    w_ps_hit;
  logic                    w_trig_edge;
  logic                    w_os_end;

  assign w_ps_hit    = (r_ps_cnt == r_p);
  assign w_trig_edge = i_trig & ~r_trig_q;
  // Same-cycle tc suppresses the strobe so a one-shot run parks the counter at FFFF.
  assign w_os_end    = r_oneshot & i_tc;

  always_comb begin
    w_next  = r_state;
    w_latch = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!i_stop && i_start) begin
          w_latch = 1'b1;
          w_next  = i_trig_en ? S_ARMED : S_RUN;
        end
      end
      S_ARMED: begin
        if (i_stop)           w_next = S_IDLE;
        else if (w_trig_edge) w_next = S_RUN;
      end
      S_RUN: begin
        if (i_stop)        w_next = S_IDLE;
        else if (w_os_end) w_next = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= S_IDLE;
      r_ps_cnt  <= '0;
      r_p       <= '0;
      r_oneshot <= 1'b0;
      r_trig_en <= 1'b0;
      r_trig_q  <= 1'b0;
    end else begin
      r_state  <= w_next;
      // Tracking trig in every state avoids a false edge from a stale sample on entry to ARMED.
      r_trig_q <= i_trig;
      if (w_latch) begin
        r_p       <= i_prescale;
        r_oneshot <= i_oneshot;
        r_trig_en <= i_trig_en;
      end
      // Held at zero outside RUN, so every entry into RUN starts from index 0.
      if (r_state != S_RUN || w_ps_hit) r_ps_cnt <= '0;
      else                              r_ps_cnt <= r_ps_cnt + 1'b1;
    end
  end

  assign o_cnt_ena = (r_state == S_RUN) & w_ps_hit & ~i_stop & ~w_os_end;
  assign o_running = (r_state == S_RUN);
  assign o_done    = (r_state == S_DONE);

  logic w_unused;
  assign w_unused = r_trig_en;

endmodule

// File: tb/tb_cnt_ena_ctrl.sv
// Bench for cnt_ena_ctrl with a behavioural 16-bit counter closing the tc loop;
// expected strobe/done events are queued by stimulus and matched by a monitor.
module tb_cnt_ena_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0, stop = 1'b0, oneshot = 1'b0, trig_en = 1'b0, trig = 1'b0;
  logic [15:0] prescale = 16'd0;
  logic        tc, cnt_ena, running, done;
  logic [15:0] cnt;

  int ntests = 0;
  int nfail  = 0;
  int cyc    = 0;

  typedef struct {
    int   cyc;
    logic ena;
    logic dn;
  } ev_t;
  ev_t q[$];

  cnt_ena_ctrl #(.PRESCALE_W(16)) dut (
    .i_clk(clk), .i_reset(reset), .i_start(start), .i_stop(stop),
    .i_oneshot(oneshot), .i_trig_en(trig_en), .i_trig(trig),
    .i_prescale(prescale), .i_tc(tc),
    .o_cnt_ena(cnt_ena), .o_running(running), .o_done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Downstream event counter sharing clock and reset.
  always @(posedge clk) begin
    if (reset)        cnt <= 16'd0;
    else if (cnt_ena) cnt <= cnt + 16'd1;
  end
  assign tc = (cnt == 16'hFFFF);

  // Monitor: every strobe or done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (cnt_ena || done) begin
      ntests++;
      if (q.size() == 0) begin
        nfail++;
        $display("FAIL event_unexpected: cyc=%0d cnt_ena=%0b done=%0b, expected no event", cyc, cnt_ena, done);
      end else begin
        ev_t e;
        e = q.pop_front();
        if (e.cyc != cyc || e.ena != cnt_ena || e.dn != done) begin
          nfail++;
          $display("FAIL event: got cyc=%0d ena=%0b done=%0b, expected cyc=%0d ena=%0b done=%0b",
                   cyc, cnt_ena, done, e.cyc, e.ena, e.dn);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Strobes at k = P, 2P+1, ... relative to the cycle index of RUN k=0.
  task automatic push_strobes(input int base, input int p, input int n);
    for (int j = 0; j < n; j++) begin
      ev_t e;
      e.cyc = base + p + j * (p + 1);
      e.ena = 1'b1;
      e.dn  = 1'b0;
      q.push_back(e);
    end
  endtask

  task automatic push_done(input int c);
    ev_t e;
    e.cyc = c;
    e.ena = 1'b0;
    e.dn  = 1'b1;
    q.push_back(e);
  endtask

  task automatic go(input logic [15:0] p, input logic os, input logic te);
    prescale = p; oneshot = os; trig_en = te; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    int base;
    // 1: reset state, free-run P=3
    tick(); tick();
    reset = 1'b0;
    chk("reset_running", {31'd0, running}, 32'd0);
    chk("reset_cnt_ena", {31'd0, cnt_ena}, 32'd0);
    chk("reset_done",    {31'd0, done},    32'd0);
    go(16'd3, 1'b0, 1'b0);
    chk("t1_running", {31'd0, running}, 32'd1);
    base = cyc;
    push_strobes(base, 3, 3);
    repeat (12) tick();
    stop = 1'b1; tick(); stop = 1'b0;
    chk("t1_stopped", {31'd0, running}, 32'd0);

    // 3: armed, trigger edge starts a P=1 run
    go(16'd1, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      chk("t3_armed_idle", {30'd0, running, cnt_ena}, 32'd0);
      tick();
    end
    trig = 1'b1;
    tick();
    chk("t3_run_after_edge", {31'd0, running}, 32'd1);
    base = cyc;
    push_strobes(base, 1, 3);
    repeat (6) tick();
    stop = 1'b1; tick(); stop = 1'b0; trig = 1'b0;
    chk("t3_stopped", {31'd0, running}, 32'd0);

    // 4: stop on a strobe cycle gates it and returns to IDLE without done
    go(16'd2, 1'b0, 1'b0);
    repeat (2) tick();
    stop = 1'b1;
    #1;
    chk("t4_stop_gates_strobe", {31'd0, cnt_ena}, 32'd0);
    tick();
    stop = 1'b0;
    chk("t4_idle", {30'd0, running, done}, 32'd0);

    // 5: start+stop together stays IDLE; reset mid-run clears everything
    start = 1'b1; stop = 1'b1;
    tick();
    chk("t5_start_stop_idle", {31'd0, running}, 32'd0);
    tick();
    chk("t5_start_stop_idle2", {31'd0, running}, 32'd0);
    start = 1'b0; stop = 1'b0;
    go(16'd3, 1'b0, 1'b0);
    base = cyc;
    push_strobes(base, 3, 1);
    repeat (4) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t5_reset_outputs", {29'd0, running, cnt_ena, done}, 32'd0);
    tick();
    chk("t5_reset_stays_idle", {29'd0, running, cnt_ena, done}, 32'd0);

    // 2: one-shot P=0 from zero stops at FFFF without wrapping
    reset = 1'b1; tick(); reset = 1'b0;
    chk("t2_cnt_zero", {16'd0, cnt}, 32'd0);
    go(16'd0, 1'b1, 1'b0);
    base = cyc;
    push_strobes(base, 0, 65535);
    push_done(base + 65536);
    repeat (65535) tick();
    chk("t2_tc_high", {31'd0, tc}, 32'd1);
    chk("t2_ena_suppressed", {31'd0, cnt_ena}, 32'd0);
    chk("t2_still_running", {31'd0, running}, 32'd1);
    tick();
    chk("t2_done_pulse", {30'd0, running, done}, 32'd1);
    tick();
    chk("t2_back_idle", {30'd0, running, done}, 32'd0);
    repeat (3) tick();
    chk("t2_cnt_holds", {16'd0, cnt}, 32'h0000FFFF);

    // 6: free-run ignores tc; prescale changes mid-run have no effect
    go(16'd3, 1'b0, 1'b0);
    chk("t6_tc_high_at_start", {31'd0, tc}, 32'd1);
    base = cyc;
    push_strobes(base, 3, 3);
    tick();
    prescale = 16'd0;
    repeat (11) tick();
    stop = 1'b1; tick(); stop = 1'b0;
    chk("t6_cnt_wrapped", {16'd0, cnt}, 32'd2);

    repeat (3) tick();
    chk("queue_drained", q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
